// File: rtl/spi_frame_pkg.sv
// Shared constants and state encoding for the SPI frame packer.
package spi_frame_pkg;
  localparam logic [63:0] MAGIC     = 64'hC691199927021942;
  localparam int          HDR_WORDS = 4;
  localparam int          TS_WORDS  = 2;

  typedef enum logic [1:0] {IDLE, HDR, TS, DATA} state_t;
endpackage

// File: rtl/sync_fifo_w16.sv
// First-word-fall-through 16-bit skid buffer; a read frees its slot for a same-cycle write.
module sync_fifo_w16 #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] din,
  input  logic        rd_en,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spi_frame_packer.sv
// Wraps buffered SPI sample words into header + timestamp + payload frames for the host FIFO.
module spi_frame_packer #(
  parameter int          NUM_WORDS = 36,
  parameter int          BUF_DEPTH = 16,
  parameter logic [63:0] MAGIC     = spi_frame_pkg::MAGIC
) (
  input  logic        dataclk,
  input  logic        fifo_reset,
  input  logic        enable,
  input  logic        frame_start,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic [15:0] FIFO_DATA_STREAM,
  output logic        FIFO_DATA_STREAM_WEN,
  output logic [31:0] timestamp,
  output logic        busy,
  output logic        frame_overrun,
  output logic        sample_drop
);
  import spi_frame_pkg::*;

  localparam logic [9:0] LAST_IDX = 10'(NUM_WORDS - 1);
  localparam logic [9:0] HDR_LAST = 10'(HDR_WORDS - 1);
  localparam logic [9:0] TS_LAST  = 10'(TS_WORDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  cnt;
  logic [9:0]  cnt_nxt;
  logic [31:0] ts_cnt;
  logic        accept;
  logic        pop;
  logic [15:0] word_nxt;
  logic        wen_nxt;
  logic [15:0] buf_dout;
  logic        buf_full;
  logic        buf_empty;

  sync_fifo_w16 #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (dataclk),
    .rst   (fifo_reset),
    .wr_en (sample_valid),
    .din   (sample_data),
    .rd_en (pop),
    .dout  (buf_dout),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign accept = frame_start && enable && (state == IDLE);
  assign busy   = (state != IDLE);

  always_ff @(posedge dataclk or posedge fifo_reset) begin
    if (fifo_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One counter walks the header, timestamp and payload phases in turn.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HDR;
          cnt_nxt   = '0;
        end
      end
      HDR: begin
        if (cnt == HDR_LAST) begin
          state_nxt = TS;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TS: begin
        if (cnt == TS_LAST) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (!buf_empty) begin
          if (cnt == LAST_IDX) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    word_nxt = '0;
    wen_nxt  = 1'b0;
    pop      = 1'b0;
    case (state)
      HDR: begin
        wen_nxt  = 1'b1;
        word_nxt = MAGIC[{cnt[1:0], 4'b0000} +: 16];
      end
      TS: begin
        wen_nxt  = 1'b1;
        word_nxt = cnt[0] ? timestamp[31:16] : timestamp[15:0];
      end
      DATA: begin
        if (!buf_empty) begin
          pop      = 1'b1;
          wen_nxt  = 1'b1;
          word_nxt = buf_dout;
        end
      end
      default: ;
    endcase
  end

  // Registered output stage; a drop is a write into a full buffer that no read relieves.
  always_ff @(posedge dataclk or posedge fifo_reset) begin
    if (fifo_reset) begin
      FIFO_DATA_STREAM     <= '0;
      FIFO_DATA_STREAM_WEN <= 1'b0;
      timestamp            <= '0;
      ts_cnt               <= '0;
      frame_overrun        <= 1'b0;
      sample_drop          <= 1'b0;
    end else begin
      FIFO_DATA_STREAM     <= word_nxt;
      FIFO_DATA_STREAM_WEN <= wen_nxt;
      if (accept) begin
        timestamp <= ts_cnt;
        ts_cnt    <= ts_cnt + 1'b1;
      end
      if (frame_start && busy) frame_overrun <= 1'b1;
      if (sample_valid && buf_full && !pop) sample_drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_frame_packer.sv
// Scoreboard bench for spi_frame_packer: stimulus queues expected words, a monitor checks the stream.
module tb_spi_frame_packer;
  logic        dataclk = 1'b0;
  logic        fifo_reset;
  logic        enable;
  logic        frame_start;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [15:0] FIFO_DATA_STREAM;
  logic        FIFO_DATA_STREAM_WEN;
  logic [31:0] timestamp;
  logic        busy;
  logic        frame_overrun;
  logic        sample_drop;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_word;

  always #5 dataclk = ~dataclk;

  spi_frame_packer #(.NUM_WORDS(36), .BUF_DEPTH(16)) dut (
    .dataclk              (dataclk),
    .fifo_reset           (fifo_reset),
    .enable               (enable),
    .frame_start          (frame_start),
    .sample_valid         (sample_valid),
    .sample_data          (sample_data),
    .FIFO_DATA_STREAM     (FIFO_DATA_STREAM),
    .FIFO_DATA_STREAM_WEN (FIFO_DATA_STREAM_WEN),
    .timestamp            (timestamp),
    .busy                 (busy),
    .frame_overrun        (frame_overrun),
    .sample_drop          (sample_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every write strobe consumes one expected word.
  always @(negedge dataclk) begin
    if (FIFO_DATA_STREAM_WEN === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=0x%04h required=no_write", FIFO_DATA_STREAM);
      end else begin
        exp_word = exp_q.pop_front();
        check("stream_word", {16'h0, FIFO_DATA_STREAM}, {16'h0, exp_word});
      end
    end
  end

  task automatic cyc();
    @(posedge dataclk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] ts, input logic [15:0] base, input int n);
    exp_q.push_back(16'h1942);
    exp_q.push_back(16'h2702);
    exp_q.push_back(16'h1999);
    exp_q.push_back(16'hC691);
    exp_q.push_back(ts[15:0]);
    exp_q.push_back(ts[31:16]);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 16'(i));
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 16'(i));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      cyc();
      n++;
    end
    check(name, 32'(n >= 2000), 32'd0);
  endtask

  task automatic do_reset();
    fifo_reset   = 1'b1;
    frame_start  = 1'b0;
    sample_valid = 1'b0;
    cyc();
    cyc();
    fifo_reset = 1'b0;
    cyc();
  endtask

  // Frame start together with the first sample, then one sample per cycle.
  task automatic feed_frame(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      frame_start  = (i == 0);
      sample_valid = 1'b1;
      sample_data  = base + 16'(i);
      cyc();
    end
    frame_start  = 1'b0;
    sample_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hdr_seen;
    fifo_reset   = 1'b1;
    enable       = 1'b0;
    frame_start  = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    cyc();
    check("rst_data", {16'h0, FIFO_DATA_STREAM}, 32'h0);
    check("rst_wen", 32'(FIFO_DATA_STREAM_WEN), 32'h0);
    check("rst_timestamp", timestamp, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_flags", {30'h0, frame_overrun, sample_drop}, 32'h0);
    fifo_reset = 1'b0;
    cyc();

    // Single frame, samples 0x0000..0x0023 one per cycle.
    enable = 1'b1;
    push_frame(32'h0, 16'h0000, 36);
    feed_frame(16'h0000, 36);
    wait_done("t1_done");
    check("t1_timestamp", timestamp, 32'h0);

    // Three frames with sparse samples; header+timestamp must be contiguous.
    do_reset();
    for (int f = 0; f < 3; f++) begin
      push_frame(32'(f), 16'(16'h0100 * (f + 1)), 36);
      frame_start  = 1'b1;
      sample_valid = 1'b1;
      sample_data  = 16'(16'h0100 * (f + 1));
      cyc();
      frame_start  = 1'b0;
      sample_valid = 1'b0;
      fork
        begin
          for (int i = 1; i < 36; i++) begin
            cyc();
            cyc();
            cyc();
            sample_valid = 1'b1;
            sample_data  = 16'(16'h0100 * (f + 1) + i);
            cyc();
            sample_valid = 1'b0;
          end
        end
        begin
          hdr_seen = 0;
          @(posedge dataclk);
          repeat (6) begin
            @(negedge dataclk);
            if (FIFO_DATA_STREAM_WEN) hdr_seen++;
          end
          check("t2_hdr_contig", 32'(hdr_seen), 32'd6);
        end
      join
      wait_done("t2_done");
      check("t2_timestamp", timestamp, 32'(f));
    end

    // enable=0 in IDLE ignores frame_start; a second start mid-frame is an overrun.
    do_reset();
    enable      = 1'b0;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    cyc();
    check("t3_disabled_busy", 32'(busy), 32'h0);
    check("t3_disabled_ovr", 32'(frame_overrun), 32'h0);
    enable = 1'b1;
    push_frame(32'h0, 16'h0300, 36);
    for (int i = 0; i < 36; i++) begin
      frame_start  = (i == 0) || (i == 10);
      enable       = (i < 20);
      sample_valid = 1'b1;
      sample_data  = 16'h0300 + 16'(i);
      cyc();
    end
    frame_start  = 1'b0;
    sample_valid = 1'b0;
    check("t3_overrun", 32'(frame_overrun), 32'h1);
    wait_done("t3_done");
    check("t3_overrun_sticky", 32'(frame_overrun), 32'h1);
    enable = 1'b1;
    push_frame(32'h1, 16'h0380, 36);
    feed_frame(16'h0380, 36);
    wait_done("t3_next_done");
    check("t3_next_ts", timestamp, 32'h1);

    // 17 samples into the 16-deep buffer with nothing draining it.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      sample_valid = 1'b1;
      sample_data  = 16'h0500 + 16'(i);
      cyc();
    end
    sample_valid = 1'b0;
    check("t4_drop", 32'(sample_drop), 32'h1);
    check("t4_idle", 32'(busy), 32'h0);
    push_frame(32'h0, 16'h0500, 16);
    push_words(16'h0600, 20);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    repeat (6) cyc();
    // First extra sample lands on the edge of the first pop, while still full.
    for (int i = 0; i < 20; i++) begin
      sample_valid = 1'b1;
      sample_data  = 16'h0600 + 16'(i);
      cyc();
    end
    sample_valid = 1'b0;
    wait_done("t4_done");
    check("t4_drop_sticky", 32'(sample_drop), 32'h1);

    // Timestamp counter wrap.
    force dut.ts_cnt = 32'hFFFF_FFFF;
    cyc();
    release dut.ts_cnt;
    push_frame(32'hFFFF_FFFF, 16'h0700, 36);
    feed_frame(16'h0700, 36);
    wait_done("t5_done");
    check("t5_timestamp", timestamp, 32'hFFFF_FFFF);
    push_frame(32'h0, 16'h0780, 36);
    feed_frame(16'h0780, 36);
    wait_done("t5_wrap_done");
    check("t5_wrap_ts", timestamp, 32'h0);

    // Reset in the middle of the payload, just before data word 5.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_data  = 16'h0900 + 16'(i);
      cyc();
    end
    sample_valid = 1'b0;
    push_frame(32'h0, 16'h0900, 5);
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge dataclk);
        #1;
        n++;
      end
      check("t6_reach_word5", 32'(n >= 200), 32'd0);
    end
    fifo_reset = 1'b1;
    #1;
    check("t6_wen_async", 32'(FIFO_DATA_STREAM_WEN), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    cyc();
    check("t6_wen_held", 32'(FIFO_DATA_STREAM_WEN), 32'h0);
    check("t6_flags", {30'h0, frame_overrun, sample_drop}, 32'h0);
    check("t6_timestamp", timestamp, 32'h0);
    fifo_reset = 1'b0;
    cyc();
    push_frame(32'h0, 16'h0A00, 36);
    feed_frame(16'h0A00, 36);
    wait_done("t6_after_done");
    check("t6_after_ts", timestamp, 32'h0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
